// File: rtl/id_ex_fwd_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_fwd_stage_pkg
// Description : Shared widths and EX operand-mux select encoding for the
//               ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_fwd_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  // EX operand mux select encoding
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_ALT   = 2'b11;

endpackage : id_ex_fwd_stage_pkg
`default_nettype wire

// File: rtl/id_ex_fwd_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_fwd_stage_if
// Description : ID-side, MEM/WB-side and EX-side signal bundle of the ID/EX
//               stage. The stage uses the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_fwd_stage_if
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
);

  logic            stall_in;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_a_pc;
  logic            id_b_imm;
  logic [RA_W-1:0] mem_rd;
  logic            mem_reg_write;
  logic [RA_W-1:0] wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_data;

  logic            id_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [1:0]      ex_sel_a;
  logic [1:0]      ex_sel_b;
  logic [1:0]      ex_sel_st;

  modport master (
    output stall_in, flush, id_valid, id_pc, id_imm, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rs1_data, id_rs2_data, id_rd,
           id_reg_write, id_mem_read, id_a_pc, id_b_imm,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, wb_data,
    input  id_stall, ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_sel_a, ex_sel_b, ex_sel_st
  );

  modport slave (
    input  stall_in, flush, id_valid, id_pc, id_imm, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rs1_data, id_rs2_data, id_rd,
           id_reg_write, id_mem_read, id_a_pc, id_b_imm,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, wb_data,
    output id_stall, ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_sel_a, ex_sel_b, ex_sel_st
  );

endinterface : id_ex_fwd_stage_if
`default_nettype wire

// File: rtl/id_ex_fwd_stage_fwd_sel_gen.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel_gen
// Description : Combinational forwarding select and same-cycle WB bypass for
//               one source operand.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel_gen
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            use_src,
  input  logic [RA_W-1:0] src,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_wr,
  input  logic            ex_load,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_wr,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_wr,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_hit,
  output logic [1:0]      sel,
  output logic [XLEN-1:0] data
);

  logic live;
  logic mem_hit;
  logic wb_hit;

  // x0 never matches: it is hardwired to zero in the regfile
  assign live    = use_src & (src != '0);
  assign ex_hit  = live & ex_wr  & (src == ex_rd);
  assign mem_hit = live & mem_wr & (src == mem_rd);
  assign wb_hit  = live & wb_wr  & (src == wb_rd);

  // A load hit in EX never reaches capture; the stage bubbles instead
  always_comb begin
    sel  = FWD_REG;
    data = rf_data;
    if (ex_hit && !ex_load) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end else if (wb_hit) begin
      data = wb_data;
    end
  end

endmodule : fwd_sel_gen
`default_nettype wire

// File: rtl/id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_fwd_stage
// Description : ID/EX pipeline register with load-use bubble insertion and
//               registered EX operand forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_fwd_stage
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_fwd_stage_if.slave  bus
);

  logic            valid_q;
  logic            reg_write_q;
  logic            mem_read_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [RA_W-1:0] rd_q;
  logic [1:0]      sel_a_q;
  logic [1:0]      sel_b_q;
  logic [1:0]      sel_st_q;

  logic            ex_wr;
  logic            rs1_ex_hit;
  logic            rs2_ex_hit;
  logic [1:0]      rs1_sel;
  logic [1:0]      rs2_sel;
  logic [XLEN-1:0] rs1_fwd_data;
  logic [XLEN-1:0] rs2_fwd_data;
  logic            load_use;
  logic            bubble;

  assign ex_wr = valid_q & reg_write_q;

  fwd_sel_gen #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_rs1_sel (
    .use_src (bus.id_use_rs1),
    .src     (bus.id_rs1),
    .rf_data (bus.id_rs1_data),
    .ex_wr   (ex_wr),
    .ex_load (mem_read_q),
    .ex_rd   (rd_q),
    .mem_wr  (bus.mem_reg_write),
    .mem_rd  (bus.mem_rd),
    .wb_wr   (bus.wb_reg_write),
    .wb_rd   (bus.wb_rd),
    .wb_data (bus.wb_data),
    .ex_hit  (rs1_ex_hit),
    .sel     (rs1_sel),
    .data    (rs1_fwd_data)
  );

  fwd_sel_gen #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_rs2_sel (
    .use_src (bus.id_use_rs2),
    .src     (bus.id_rs2),
    .rf_data (bus.id_rs2_data),
    .ex_wr   (ex_wr),
    .ex_load (mem_read_q),
    .ex_rd   (rd_q),
    .mem_wr  (bus.mem_reg_write),
    .mem_rd  (bus.mem_rd),
    .wb_wr   (bus.wb_reg_write),
    .wb_rd   (bus.wb_rd),
    .wb_data (bus.wb_data),
    .ex_hit  (rs2_ex_hit),
    .sel     (rs2_sel),
    .data    (rs2_fwd_data)
  );

  assign load_use     = bus.id_valid & valid_q & mem_read_q & (rs1_ex_hit | rs2_ex_hit);
  assign bubble       = bus.flush | load_use;
  assign bus.id_stall = load_use & ~bus.flush & ~bus.stall_in;

  // Bubbles still latch the ID fields so EX data stays deterministic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rd_q        <= '0;
      sel_a_q     <= FWD_REG;
      sel_b_q     <= FWD_REG;
      sel_st_q    <= FWD_REG;
    end else if (!bus.stall_in) begin
      valid_q     <= bus.id_valid     & ~bubble;
      reg_write_q <= bus.id_reg_write & ~bubble;
      mem_read_q  <= bus.id_mem_read  & ~bubble;
      pc_q        <= bus.id_pc;
      imm_q       <= bus.id_imm;
      rs1_data_q  <= rs1_fwd_data;
      rs2_data_q  <= rs2_fwd_data;
      rd_q        <= bus.id_rd;
      sel_a_q     <= bus.id_a_pc  ? FWD_ALT : rs1_sel;
      sel_b_q     <= bus.id_b_imm ? FWD_ALT : rs2_sel;
      sel_st_q    <= rs2_sel;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_reg_write = reg_write_q;
  assign bus.ex_mem_read  = mem_read_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_rs1_data  = rs1_data_q;
  assign bus.ex_rs2_data  = rs2_data_q;
  assign bus.ex_rd        = rd_q;
  assign bus.ex_sel_a     = sel_a_q;
  assign bus.ex_sel_b     = sel_b_q;
  assign bus.ex_sel_st    = sel_st_q;

endmodule : id_ex_fwd_stage
`default_nettype wire

// File: tb/tb_id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_fwd_stage
// Description : Directed table-driven bench for the ID/EX forwarding stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_fwd_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_ex_fwd_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  id_ex_fwd_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        iv;
    logic        flush;
    logic [4:0]  rs1;
    logic        u1;
    logic [31:0] d1;
    logic [4:0]  rs2;
    logic        u2;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        apc;
    logic        bimm;
    logic [4:0]  mrd;
    logic        mrw;
    logic [4:0]  wrd;
    logic        wrw;
    logic [31:0] wdata;
    logic        x_stall;
    logic        x_bubble;
    logic [13:0] x_ctl;
    logic [31:0] x_d1;
    logic [31:0] x_d2;
  } vec_t;

  localparam int NV = 16;
  vec_t vt[NV];
  vec_t s;

  int passed = 0;
  int total  = 0;

  function automatic logic [13:0] ctl(input logic v, input logic rw, input logic mr,
                                      input logic [4:0] rd, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] sst);
    return {v, rw, mr, rd, sa, sb, sst};
  endfunction

  function automatic logic [13:0] out_ctl();
    return {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_rd,
            bus.ex_sel_a, bus.ex_sel_b, bus.ex_sel_st};
  endfunction

  function automatic logic [127:0] out_data();
    return {bus.ex_pc, bus.ex_imm, bus.ex_rs1_data, bus.ex_rs2_data};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pc, input logic [31:0] imm);
    bus.id_valid      = v.iv;
    bus.flush         = v.flush;
    bus.id_pc         = pc;
    bus.id_imm        = imm;
    bus.id_rs1        = v.rs1;
    bus.id_use_rs1    = v.u1;
    bus.id_rs1_data   = v.d1;
    bus.id_rs2        = v.rs2;
    bus.id_use_rs2    = v.u2;
    bus.id_rs2_data   = v.d2;
    bus.id_rd         = v.rd;
    bus.id_reg_write  = v.rw;
    bus.id_mem_read   = v.mr;
    bus.id_a_pc       = v.apc;
    bus.id_b_imm      = v.bimm;
    bus.mem_rd        = v.mrd;
    bus.mem_reg_write = v.mrw;
    bus.wb_rd         = v.wrd;
    bus.wb_reg_write  = v.wrw;
    bus.wb_data       = v.wdata;
  endtask

  initial begin
    //        iv fl rs1 u1 d1            rs2 u2 d2            rd rw mr apc bimm mrd mrw wrd wrw wdata          stl bub ctl                                   xd1            xd2
    vt[0]  = '{1, 0, 1,  1, 32'h11,       2,  1, 32'h22,       5, 1, 0, 0, 0,   0, 0,   0, 0, 32'h0,        0, 0, ctl(1,1,0,5, 2'b00,2'b00,2'b00),  32'h11,       32'h22};
    vt[1]  = '{1, 0, 5,  1, 32'h55,       0,  0, 32'h66,       6, 1, 0, 0, 1,   0, 0,   0, 0, 32'h0,        0, 0, ctl(1,1,0,6, 2'b01,2'b11,2'b00),  32'h55,       32'h66};
    vt[2]  = '{1, 0, 1,  1, 32'ha1,       7,  1, 32'ha2,       0, 0, 0, 0, 0,   7, 1,   0, 0, 32'h0,        0, 0, ctl(1,0,0,0, 2'b00,2'b10,2'b10),  32'ha1,       32'ha2};
    vt[3]  = '{1, 0, 1,  1, 32'hb1,       0,  1, 32'hb2,       0, 0, 0, 0, 0,   0, 1,   0, 0, 32'h0,        0, 0, ctl(1,0,0,0, 2'b00,2'b00,2'b00),  32'hb1,       32'hb2};
    vt[4]  = '{1, 0, 2,  1, 32'hc1,       0,  0, 32'hc2,       3, 1, 1, 0, 1,   0, 0,   0, 0, 32'h0,        0, 0, ctl(1,1,1,3, 2'b00,2'b11,2'b00),  32'hc1,       32'hc2};
    vt[5]  = '{1, 0, 1,  1, 32'hd1,       3,  1, 32'hd2,       4, 1, 0, 0, 0,   0, 0,   0, 0, 32'h0,        1, 1, ctl(0,0,0,0, 2'b00,2'b00,2'b00),  32'h0,        32'h0};
    vt[6]  = '{1, 0, 1,  1, 32'hd1,       3,  1, 32'hd2,       4, 1, 0, 0, 0,   3, 1,   0, 0, 32'h0,        0, 0, ctl(1,1,0,4, 2'b00,2'b10,2'b10),  32'hd1,       32'hd2};
    vt[7]  = '{1, 0, 9,  1, 32'h1,        0,  0, 32'he2,      10, 1, 0, 0, 0,   0, 0,   9, 1, 32'hDEADBEEF, 0, 0, ctl(1,1,0,10,2'b00,2'b00,2'b00),  32'hDEADBEEF, 32'he2};
    vt[8]  = '{1, 0, 10, 1, 32'hf1,       10, 1, 32'hf2,      11, 1, 0, 1, 0,   0, 0,   0, 0, 32'h0,        0, 0, ctl(1,1,0,11,2'b11,2'b01,2'b01),  32'hf1,       32'hf2};
    vt[9]  = '{1, 0, 11, 1, 32'h91,       0,  0, 32'h92,      14, 1, 0, 0, 0,  11, 1,  11, 1, 32'hBAD,      0, 0, ctl(1,1,0,14,2'b01,2'b00,2'b00),  32'h91,       32'h92};
    vt[10] = '{1, 0, 12, 1, 32'ha01,      14, 1, 32'ha02,      0, 0, 0, 0, 0,  12, 1,  12, 1, 32'hCAFE,     0, 0, ctl(1,0,0,0, 2'b10,2'b01,2'b01),  32'ha01,      32'ha02};
    vt[11] = '{1, 0, 12, 0, 32'hb01,      12, 0, 32'hb02,      0, 0, 0, 0, 0,  12, 1,  12, 1, 32'hCAFE,     0, 0, ctl(1,0,0,0, 2'b00,2'b00,2'b00),  32'hb01,      32'hb02};
    vt[12] = '{1, 0, 5,  1, 32'hc01,      5,  1, 32'hc02,      0, 0, 0, 0, 0,   0, 0,   5, 0, 32'h5555,     0, 0, ctl(1,0,0,0, 2'b00,2'b00,2'b00),  32'hc01,      32'hc02};
    vt[13] = '{1, 0, 0,  1, 32'hd01,      13, 1, 32'hd02,      0, 0, 0, 0, 0,   0, 0,  13, 1, 32'h1313,     0, 0, ctl(1,0,0,0, 2'b00,2'b00,2'b00),  32'hd01,      32'h1313};
    vt[14] = '{1, 0, 0,  1, 32'he01,      0,  0, 32'he02,      0, 0, 0, 0, 0,   0, 0,   0, 1, 32'h777,      0, 0, ctl(1,0,0,0, 2'b00,2'b00,2'b00),  32'he01,      32'he02};
    vt[15] = '{0, 0, 1,  0, 32'h0,        2,  0, 32'h0,        0, 0, 0, 0, 0,   0, 0,   0, 0, 32'h0,        0, 0, ctl(0,0,0,0, 2'b00,2'b00,2'b00),  32'h0,        32'h0};

    // Reset state
    rst          = 1'b0;
    bus.stall_in = 1'b0;
    s = '{0,0, 0,0,32'h0, 0,0,32'h0, 0,0,0,0,0, 0,0, 0,0,32'h0, 0,0, 14'h0, 32'h0, 32'h0};
    drive(s, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("reset_ctl",  {114'h0, out_ctl()}, 128'h0);
    chk("reset_data", out_data(), 128'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table: stall checked before the edge, EX registers after it
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i], 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      #1;
      chk($sformatf("v%0d_id_stall", i), {127'h0, bus.id_stall}, {127'h0, vt[i].x_stall});
      @(posedge clk); #1;
      if (vt[i].x_bubble) begin
        chk($sformatf("v%0d_bubble", i), {125'h0, out_ctl() >> 11}, {125'h0, vt[i].x_ctl >> 11});
      end else begin
        chk($sformatf("v%0d_ctl", i), {114'h0, out_ctl()}, {114'h0, vt[i].x_ctl});
        chk($sformatf("v%0d_data", i), out_data(),
            {32'h100 + 32'(4 * i), 32'h1000 + 32'(i), vt[i].x_d1, vt[i].x_d2});
      end
    end

    // Flush coinciding with a load-use hazard
    @(negedge clk);
    s = '{1,0, 0,0,32'h0, 0,0,32'h0, 3,1,1,0,1, 0,0, 0,0,32'h0, 0,0, 14'h0, 32'h0, 32'h0};
    drive(s, 32'h180, 32'h8);
    @(posedge clk); #1;
    @(negedge clk);
    s = '{1,0, 3,1,32'h31, 0,0,32'h32, 4,1,0,0,0, 0,0, 0,0,32'h0, 0,0, 14'h0, 32'h0, 32'h0};
    drive(s, 32'h184, 32'h0);
    #1;
    chk("lu_stall", {127'h0, bus.id_stall}, {127'h0, 1'b1});
    bus.flush = 1'b1;
    #1;
    chk("flush_lu_stall", {127'h0, bus.id_stall}, 128'h0);
    @(posedge clk); #1;
    chk("flush_bubble", {125'h0, out_ctl() >> 11}, 128'h0);

    // Hold for three cycles with a hazard pending in ID
    @(negedge clk);
    s = '{1,0, 1,1,32'h1111, 2,1,32'h2222, 8,1,0,1,0, 0,0, 0,0,32'h0, 0,0, 14'h0, 32'h0, 32'h0};
    drive(s, 32'h200, 32'h2000);
    @(posedge clk); #1;
    chk("seqb_add_ctl", {114'h0, out_ctl()}, {114'h0, ctl(1,1,0,8, 2'b11,2'b00,2'b00)});
    @(negedge clk);
    s = '{1,0, 0,0,32'h3333, 8,1,32'h4444, 9,1,1,0,0, 0,0, 0,0,32'h0, 0,0, 14'h0, 32'h0, 32'h0};
    drive(s, 32'h204, 32'h2004);
    @(posedge clk); #1;
    chk("seqb_lw_ctl", {114'h0, out_ctl()}, {114'h0, ctl(1,1,1,9, 2'b00,2'b01,2'b01)});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.stall_in = 1'b1;
      s = '{1,0, 9,1,32'h77, 8,1,32'h88, 1,1,0,0,0, 9,1, 8,1,32'h99, 0,0, 14'h0, 32'h0, 32'h0};
      drive(s, 32'h300 + 32'(4 * c), 32'h3000);
      #1;
      chk($sformatf("hold%0d_id_stall", c), {127'h0, bus.id_stall}, 128'h0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_ctl", c), {114'h0, out_ctl()}, {114'h0, ctl(1,1,1,9, 2'b00,2'b01,2'b01)});
      chk($sformatf("hold%0d_data", c), out_data(), {32'h204, 32'h2004, 32'h3333, 32'h4444});
    end
    @(negedge clk);
    bus.stall_in = 1'b0;
    #1;
    chk("post_hold_stall", {127'h0, bus.id_stall}, {127'h0, 1'b1});
    @(posedge clk); #1;
    chk("post_hold_bubble", {125'h0, out_ctl() >> 11}, 128'h0);

    // Asynchronous reset between edges discards EX
    @(negedge clk);
    s = '{1,0, 0,0,32'h0, 0,0,32'h0, 2,1,0,0,0, 0,0, 0,0,32'h0, 0,0, 14'h0, 32'h0, 32'h0};
    drive(s, 32'h400, 32'h4000);
    @(posedge clk); #1;
    chk("pre_rst_ctl", {114'h0, out_ctl()}, {114'h0, ctl(1,1,0,2, 2'b00,2'b00,2'b00)});
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_ctl",  {114'h0, out_ctl()}, 128'h0);
    chk("async_rst_data", out_data(), 128'h0);
    @(posedge clk); #1;
    chk("rst_held_ctl", {114'h0, out_ctl()}, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    s = '{1,0, 2,1,32'h5, 2,1,32'h6, 6,1,0,0,0, 0,0, 0,0,32'h0, 0,0, 14'h0, 32'h0, 32'h0};
    drive(s, 32'h500, 32'h5000);
    @(posedge clk); #1;
    chk("post_rst_ctl",  {114'h0, out_ctl()}, {114'h0, ctl(1,1,0,6, 2'b00,2'b00,2'b00)});
    chk("post_rst_data", out_data(), {32'h500, 32'h5000, 32'h5, 32'h6});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_id_ex_fwd_stage
`default_nettype wire
